uart_tx_serializer: RTL and testbench

- UART transmitter; the transmit-side counterpart to the team's oversampling UART receiver on the same line format.
- Accepts one parallel word per valid/ready handshake and serialises it on Tx: start bit, data LSB first, optional parity, then 1 or 2 stop bits.
- Runs on the 16x baud clock. Each bit is held for OVERSAMPLE clock cycles.
- Line configuration (length, parity, stop bits) is captured per frame, so the receiver decodes the output with identical settings.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_serializer_if.sv | 24 ++
 rtl/uart_bit_timer.sv | 23 ++
 rtl/uart_tx_serializer.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, default timing and parity-type constants.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int unsigned SAMPLES_PER_BIT = 16;
  localparam int unsigned MAX_FRAME_BITS  = 9;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
`ifdef UART_TX_BREAK_EN
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
`else
    ST_STOP   = 3'd4
`endif
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Word/config handshake between a frame source and the UART transmitter.
interface uart_tx_serializer_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = MAX_FRAME_BITS
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              parity;
  logic              parity_type;
  logic              stop_bits;
  logic [3:0]        frame_length;

  modport master (
    output tx_data, tx_valid, parity, parity_type, stop_bits, frame_length,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, parity, parity_type, stop_bits, frame_length,
    output tx_ready
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit sample counter: bit_end marks the last oversample clock of a bit; clear holds it at zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = SAMPLES_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] sample_cnt;

  assign bit_end = (sample_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || bit_end) sample_cnt <= '0;
    else                         sample_cnt <= sample_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits, OVERSAMPLE clocks per bit.
// Define UART_TX_BREAK_EN to add the tx_break input and the BREAK line state.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = SAMPLES_PER_BIT,
  parameter int unsigned DATA_W     = MAX_FRAME_BITS
) (
  input  logic                 clk_16bd,
  input  logic                 rst,
  uart_tx_serializer_if.slave  bus,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 Tx,
  output logic                 tx_done
);
  localparam int unsigned IDX_W = 5;
  localparam logic [3:0] MAX_LEN = 4'(DATA_W);
`ifdef UART_TX_BREAK_EN
  localparam logic [IDX_W-1:0] BRK_LAST = IDX_W'(2 + DATA_W);
`endif

  uart_state_e       state, state_n;
  logic [DATA_W-1:0] data_q, data_sh;
  logic [3:0]        len_q, len_c;
  logic              par_en_q, par_q, par_c, stop2_q;
  logic              stop_cnt, stop_cnt_n;
  logic [IDX_W-1:0]  bit_idx, bit_idx_n, last_idx;
  logic              ready_q, accept, bit_end, timer_clear, tx_n, done_n;
`ifdef UART_TX_BREAK_EN
  logic              brk_hi, brk_hi_n;
`endif

  assign timer_clear  = (state == ST_IDLE);
  assign bus.tx_ready = ready_q;
  assign last_idx     = IDX_W'(len_q) - IDX_W'(1);
  assign data_sh      = data_q >> bit_idx_n;

`ifdef UART_TX_BREAK_EN
  assign accept = ready_q && bus.tx_valid && !tx_break;
`else
  assign accept = ready_q && bus.tx_valid;
`endif

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .clk     (clk_16bd),
    .rst     (rst),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

  // Parity is resolved at accept time over only the first len_c data bits.
  always_comb begin
    len_c = bus.frame_length;
    if (bus.frame_length == 4'd0)       len_c = 4'd1;
    else if (bus.frame_length > MAX_LEN) len_c = MAX_LEN;
    par_c = (bus.parity_type == PARITY_ODD);
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < 32'(len_c)) par_c = par_c ^ bus.tx_data[i];
    end
  end

  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    done_n     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_hi_n   = brk_hi;
`endif
    case (state)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_n   = ST_BREAK;
          bit_idx_n = '0;
          brk_hi_n  = 1'b0;
        end else
`endif
        if (accept) state_n = ST_START;
      end
      ST_START: if (bit_end) begin
        state_n   = ST_DATA;
        bit_idx_n = '0;
      end
      ST_DATA: if (bit_end) begin
        if (bit_idx == last_idx) begin
          state_n    = par_en_q ? ST_PARITY : ST_STOP;
          stop_cnt_n = 1'b0;
        end else begin
          bit_idx_n = bit_idx + IDX_W'(1);
        end
      end
      ST_PARITY: if (bit_end) begin
        state_n    = ST_STOP;
        stop_cnt_n = 1'b0;
      end
      ST_STOP: if (bit_end) begin
        if (stop2_q && !stop_cnt) begin
          stop_cnt_n = 1'b1;
        end else begin
          state_n    = ST_IDLE;
          stop_cnt_n = 1'b0;
          done_n     = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      // Low phase spans whole bit times until both the minimum length and tx_break release are met.
      ST_BREAK: if (bit_end) begin
        if (brk_hi)                                   state_n   = ST_IDLE;
        else if (bit_idx >= BRK_LAST && !tx_break)    brk_hi_n  = 1'b1;
        else if (bit_idx < BRK_LAST)                  bit_idx_n = bit_idx + IDX_W'(1);
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    // Tx is registered from the next state so the line changes on the same edge as the FSM.
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = data_sh[0];
      ST_PARITY: tx_n = par_q;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_n = brk_hi_n;
`endif
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      ready_q  <= 1'b0;
      Tx       <= 1'b1;
      tx_done  <= 1'b0;
      data_q   <= '0;
      len_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_hi   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      ready_q  <= (state_n == ST_IDLE);
      Tx       <= tx_n;
      tx_done  <= done_n;
`ifdef UART_TX_BREAK_EN
      brk_hi   <= brk_hi_n;
`endif
      if (accept) begin
        data_q   <= bus.tx_data;
        len_q    <= len_c;
        par_en_q <= bus.parity;
        par_q    <= par_c;
        stop2_q  <= bus.stop_bits;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: drivers queue hand-computed line bit patterns, a monitor checks Tx per cycle.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
  localparam int unsigned OS = 16;
  localparam int unsigned DW = 9;

  logic clk_16bd = 1'b0;
  logic rst      = 1'b1;
  logic Tx, tx_done;
`ifdef UART_TX_BREAK_EN
  logic tx_break = 1'b0;
`endif

  uart_tx_serializer_if #(.DATA_W(DW)) bus ();

  uart_tx_serializer #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
    .clk_16bd (clk_16bd),
    .rst      (rst),
    .bus      (bus),
`ifdef UART_TX_BREAK_EN
    .tx_break (tx_break),
`endif
    .Tx       (Tx),
    .tx_done  (tx_done)
  );

  always #5 clk_16bd = ~clk_16bd;

  // bits[i] is the i-th line bit (bit 0 = start); nbits == 0 marks a frame expected to be cut by reset.
  typedef struct {
    logic [15:0] bits;
    int unsigned nbits;
    int          gap;
    logic        done_exp;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  logic        in_frame = 1'b0;
  logic        done_due = 1'b0;
  exp_t        cur;
  int unsigned cyc = 0, errs = 0, rdy_errs = 0, idle_cnt = 100;

  always @(negedge clk_16bd) begin
    if (rst) begin
      if (in_frame) check("abort_on_reset", 32'(cur.nbits), 32'd0);
      in_frame = 1'b0;
      done_due = 1'b0;
      idle_cnt = 100;
    end else begin
      if (done_due || tx_done) check("tx_done", 32'(tx_done), 32'(done_due));
      done_due = 1'b0;
      if (!in_frame && Tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(Tx), 32'd1);
        end else begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          cyc      = 0;
          errs     = 0;
          rdy_errs = 0;
          if (cur.gap >= 0) check("idle_gap", 32'(idle_cnt), 32'(cur.gap));
        end
      end
      if (in_frame) begin
        if (cur.nbits != 0 && Tx !== cur.bits[cyc / OS]) errs++;
        if (bus.tx_ready !== 1'b0) rdy_errs++;
        if (cur.nbits != 0 && cyc == cur.nbits * OS - 1) begin
          check("frame_bits", 32'(errs), 32'd0);
          check("ready_low", 32'(rdy_errs), 32'd0);
          done_due = cur.done_exp;
          in_frame = 1'b0;
          idle_cnt = 0;
        end else begin
          cyc++;
        end
      end else begin
        idle_cnt++;
      end
    end
  end

  task automatic send(input logic [8:0] d, input logic [3:0] len, input logic p, input logic pt,
                      input logic s2, input logic hold, input logic [15:0] bits,
                      input int unsigned nbits, input int gap);
    exp_t e;
    int unsigned n;
    e.bits = bits; e.nbits = nbits; e.gap = gap; e.done_exp = 1'b1;
    exp_q.push_back(e);
    bus.tx_data      = d;
    bus.frame_length = len;
    bus.parity       = p;
    bus.parity_type  = pt;
    bus.stop_bits    = s2;
    bus.tx_valid     = 1'b1;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 2000) begin
      @(posedge clk_16bd); #1;
      n++;
    end
    if (n >= 2000) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk_16bd); #1;
    if (!hold) bus.tx_valid = 1'b0;
    // Disturb every input after accept; the frame in flight must not change.
    bus.tx_data      = ~d;
    bus.frame_length = len + 4'd3;
    bus.parity       = ~p;
    bus.parity_type  = ~pt;
    bus.stop_bits    = ~s2;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
      @(posedge clk_16bd); #1;
      n++;
    end
    if (n >= 3000) check("idle_timeout", 32'(n), 32'd0);
    repeat (4) @(posedge clk_16bd);
    #1;
  endtask

  initial begin
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.frame_length = 4'd8;
    bus.parity = 1'b0; bus.parity_type = 1'b0; bus.stop_bits = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk_16bd);
    #1;
    check("reset_tx", 32'(Tx), 32'd1);
    check("reset_ready", 32'(bus.tx_ready), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    @(posedge clk_16bd); #1;
    check("ready_after_reset", 32'(bus.tx_ready), 32'd1);

    send(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'b0000_0011_0100_1010, 10, -1); wait_idle();
    send(9'h007, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'b0000_0011_0000_1110, 10, -1); wait_idle();
    send(9'h007, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 16'b0000_0110_0000_1110, 11, -1); wait_idle();
    send(9'h1FF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 16'b0000_0111_1111_1110, 11, -1); wait_idle();
    send(9'h1FE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'b0000_0000_0000_0100,  3, -1); wait_idle();
    send(9'h155, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'b0000_0110_1010_1010, 11, -1); wait_idle();
    send(9'h1F8, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'b0000_0000_0010_0000,  6, -1); wait_idle();
    send(9'h0FE, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'b0000_0000_0011_1100,  6, -1); wait_idle();

    // tx_valid held across three frames: exactly one idle cycle between them.
    send(9'h015, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'b0000_0000_0110_1010, 7, -1);
    send(9'h00A, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'b0000_0000_0101_0100, 7,  1);
    send(9'h01F, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'b0000_0000_1111_1110, 8,  1);
    wait_idle();

    // Reset during data bit 3, then an intact frame.
    send(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, -1);
    repeat (70) @(posedge clk_16bd);
    #1;
    rst = 1'b1;
    @(posedge clk_16bd); #1;
    check("midframe_reset_tx", 32'(Tx), 32'd1);
    check("midframe_reset_ready", 32'(bus.tx_ready), 32'd0);
    check("midframe_reset_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    @(posedge clk_16bd); #1;
    check("ready_after_midframe_reset", 32'(bus.tx_ready), 32'd1);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    send(9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'b0000_0010_0111_1000, 10, -1); wait_idle();

`ifdef UART_TX_BREAK_EN
    begin
      exp_t e;
      e.bits = 16'b0001_0000_0000_0000; e.nbits = 13; e.gap = -1; e.done_exp = 1'b0;
      exp_q.push_back(e);
      tx_break = 1'b1;
      repeat (50) @(posedge clk_16bd);
      #1;
      tx_break = 1'b0;
      wait_idle();
      check("ready_after_break", 32'(bus.tx_ready), 32'd1);
    end
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
